// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared defaults and writeback entry type for reg_writeback
package reg_wb_pkg;
  localparam int DEPTH_DEF = 32;
  localparam int BITS_DEF  = 64;
  localparam int ADDR_W    = $clog2(DEPTH_DEF);
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [BITS_DEF-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: writeback queue with two ordered push ports and one pop port
//   i_push0/i_addr0/i_data0 : first push, stored ahead of push1 when both fire
//   i_push1/i_addr1/i_data1 : second push
//   i_pop                   : remove head entry
//   o_count                 : occupancy
//   o_valid/o_addr/o_data   : contents in age order, index 0 = head (oldest)
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int AW     = ADDR_W,
  parameter int BW     = BITS_DEF,
  parameter int QDEPTH = 4,
  localparam int PW    = $clog2(QDEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push0,
  input  logic [AW-1:0] i_addr0,
  input  logic [BW-1:0] i_data0,
  input  logic          i_push1,
  input  logic [AW-1:0] i_addr1,
  input  logic [BW-1:0] i_data1,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output logic [QDEPTH-1:0] o_valid,
  output logic [AW-1:0] o_addr [QDEPTH],
  output logic [BW-1:0] o_data [QDEPTH]
);
  logic [AW-1:0] r_addr [QDEPTH];
  logic [BW-1:0] r_data [QDEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [1:0]    w_npush;
  assign w_npush = {1'b0, i_push0} + {1'b0, i_push1};
  assign o_count = r_count;
  // storage needs no reset: validity comes from the pointers and count
  always_ff @(posedge clk) begin
    if (i_push0 | i_push1) begin
      r_addr[r_wptr] <= i_push0 ? i_addr0 : i_addr1;
      r_data[r_wptr] <= i_push0 ? i_data0 : i_data1;
    end
    if (i_push0 & i_push1) begin
      r_addr[r_wptr + PW'(1)] <= i_addr1;
      r_data[r_wptr + PW'(1)] <= i_data1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_npush);
      r_rptr  <= r_rptr + PW'(i_pop);
      r_count <= r_count + CW'(w_npush) - CW'(i_pop);
    end
  end
  always_comb begin
    for (int k = 0; k < QDEPTH; k++) begin
      o_valid[k] = CW'(k) < r_count;
      o_addr[k]  = r_addr[r_rptr + PW'(k)];
      o_data[k]  = r_data[r_rptr + PW'(k)];
    end
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU/load results into a writeback queue draining to the register file
//   alu_*/mem_*            : result offers with valid/ready handshakes (load has priority on space)
//   addressw/writeData/writeEn : register file write port, one entry per cycle
//   busy                   : per-register pending-write scoreboard
//   address1/2, fwd_*      : forwarding lookup of youngest queued value
//   Optional forwarding compiled in with macro REG_WB_FORWARD_EN
module reg_writeback
  import reg_wb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int BITS   = BITS_DEF,
  parameter int QDEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(QDEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [BITS-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_addr,
  input  logic [BITS-1:0] mem_data,
  output logic            mem_ready,
  output logic [AW-1:0]   addressw,
  output logic [BITS-1:0] writeData,
  output logic            writeEn,
  output logic [DEPTH-1:0] busy,
  input  logic [AW-1:0]   address1,
  input  logic [AW-1:0]   address2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [BITS-1:0] fwd_data1,
  output logic [BITS-1:0] fwd_data2
);
  logic [CW-1:0]     w_count;
  logic [QDEPTH-1:0] w_valid;
  logic [AW-1:0]     w_addr [QDEPTH];
  logic [BITS-1:0]   w_data [QDEPTH];
  logic              w_push_mem, w_push_alu;
  // space is judged on occupancy at cycle start; the pop of this cycle is not credited
  assign mem_ready  = w_count < CW'(QDEPTH);
  assign alu_ready  = (w_count <= CW'(QDEPTH - 2)) | (mem_ready & ~mem_valid);
  assign w_push_mem = mem_valid & mem_ready & |mem_addr;
  assign w_push_alu = alu_valid & alu_ready & |alu_addr;
  wb_fifo #(.AW(AW), .BW(BITS), .QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push0 (w_push_mem),
    .i_addr0 (mem_addr),
    .i_data0 (mem_data),
    .i_push1 (w_push_alu),
    .i_addr1 (alu_addr),
    .i_data1 (alu_data),
    .i_pop   (w_valid[0]),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_addr  (w_addr),
    .o_data  (w_data)
  );
  assign writeEn   = w_valid[0];
  assign addressw  = w_valid[0] ? w_addr[0] : '0;
  assign writeData = w_valid[0] ? w_data[0] : '0;
  always_comb begin
    busy = '0;
    for (int k = 0; k < QDEPTH; k++)
      if (w_valid[k]) busy[w_addr[k]] = 1'b1;
    busy[0] = 1'b0;
  end
`ifdef REG_WB_FORWARD_EN
  // scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      if (w_valid[k] && |address1 && w_addr[k] == address1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = w_data[k];
      end
      if (w_valid[k] && |address2 && w_addr[k] == address2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = w_data[k];
      end
    end
  end
`else
  logic w_unused;
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
  always_comb begin
    w_unused = ^{address1, address2};
    for (int k = 1; k < QDEPTH; k++) w_unused = w_unused ^ (^w_data[k]);
  end
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: randomized and directed checks of reg_writeback against a queue model
module tb_reg_writeback;
  import reg_wb_pkg::*;
  localparam int QD = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_addr = '0, mem_addr = '0, address1 = '0, address2 = '0;
  logic [63:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, writeEn, fwd_hit1, fwd_hit2;
  logic [4:0]  addressw;
  logic [63:0] writeData, fwd_data1, fwd_data2;
  logic [31:0] busy;
  int          n_chk = 0, n_err = 0;
  wb_entry_t   q[$];
  always #5 clk = ~clk;
  reg_writeback #(.DEPTH(32), .BITS(64), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .addressw(addressw), .writeData(writeData), .writeEn(writeEn), .busy(busy),
    .address1(address1), .address2(address2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (q[i]) b[q[i].addr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction
  function automatic logic [64:0] model_fwd(input logic [4:0] a);
`ifdef REG_WB_FORWARD_EN
    if (a != 0)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].addr == a) return {1'b1, q[i].data};
`endif
    return '0;
  endfunction
  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask
  task automatic offer(input logic mv, input logic [4:0] ma, input logic [63:0] md,
                       input logic av, input logic [4:0] aa, input logic [63:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask
  task automatic step();
    int          free;
    logic        mr, ar;
    logic [64:0] f1, f2;
    @(negedge clk);
    free = QD - q.size();
    mr = free >= 1;
    ar = free >= 2 || (free >= 1 && !mem_valid);
    f1 = model_fwd(address1);
    f2 = model_fwd(address2);
    check("mem_ready", 64'(mem_ready), 64'(mr));
    check("alu_ready", 64'(alu_ready), 64'(ar));
    check("writeEn", 64'(writeEn), 64'(q.size() != 0));
    check("addressw", 64'(addressw), q.size() != 0 ? 64'(q[0].addr) : 64'd0);
    check("writeData", writeData, q.size() != 0 ? q[0].data : 64'd0);
    check("busy", 64'(busy), 64'(model_busy()));
    check("fwd_hit1", 64'(fwd_hit1), 64'(f1[64]));
    check("fwd_data1", fwd_data1, f1[63:0]);
    check("fwd_hit2", 64'(fwd_hit2), 64'(f2[64]));
    check("fwd_data2", fwd_data2, f2[63:0]);
    if (q.size() != 0) void'(q.pop_front());
    if (mem_valid && mr && mem_addr != 0) q.push_back('{addr: mem_addr, data: mem_data});
    if (alu_valid && ar && alu_addr != 0) q.push_back('{addr: alu_addr, data: alu_data});
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    check("rst_writeEn", 64'(writeEn), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_mem_ready", 64'(mem_ready), 64'd1);
    check("post_rst_alu_ready", 64'(alu_ready), 64'd1);
    // single load write, one cycle latency
    offer(1, 5'd5, 64'hAA, 0, 0, 0);
    step();
    idle(); #1;
    check("ld_writeEn", 64'(writeEn), 64'd1);
    check("ld_addressw", 64'(addressw), 64'd5);
    check("ld_writeData", writeData, 64'hAA);
    step();
    check("ld_drained", 64'(writeEn), 64'd0);
    // simultaneous offers: load first, then ALU
    offer(1, 5'd4, 64'h22, 1, 5'd3, 64'h11);
    step();
    idle(); #1;
    check("both_first", 64'(addressw), 64'd4);
    step();
    check("both_second", 64'(addressw), 64'd3);
    check("both_second_data", writeData, 64'h11);
    step();
    step();
    // grow occupancy to one free slot, then offer both
    offer(1, 5'd8, 64'h1, 1, 5'd9, 64'h2);
    step();
    offer(1, 5'd10, 64'h3, 1, 5'd11, 64'h4);
    step();
    #1;
    check("onefree_mem_ready", 64'(mem_ready), 64'd1);
    check("onefree_alu_ready", 64'(alu_ready), 64'd0);
    idle();
    repeat (4) step();
    // register 0 offers are dropped
    offer(0, 0, 0, 1, 5'd0, 64'hFF);
    step();
    idle(); #1;
    check("x0_writeEn", 64'(writeEn), 64'd0);
    check("x0_busy", 64'(busy), 64'd0);
    // two pending writes to the same register
    offer(1, 5'd7, 64'h1, 1, 5'd7, 64'h2);
    step();
    idle();
    address1 = 5'd7; #1;
    check("dup_busy7", 64'(busy[7]), 64'd1);
`ifdef REG_WB_FORWARD_EN
    check("dup_fwd_hit1", 64'(fwd_hit1), 64'd1);
    check("dup_fwd_data1", fwd_data1, 64'h2);
`else
    check("dup_fwd_hit1", 64'(fwd_hit1), 64'd0);
`endif
    step();
    step();
    // reset with three entries queued
    offer(1, 5'd12, 64'h5, 1, 5'd13, 64'h6);
    step();
    offer(1, 5'd14, 64'h7, 1, 5'd15, 64'h8);
    step();
    idle();
    check("pre_rst_depth", 64'(q.size()), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_writeEn", 64'(writeEn), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_fwd_hit1", 64'(fwd_hit1), 64'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step();
    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      offer($urandom_range(0, 1), 5'($urandom_range(0, 9)), {$urandom, $urandom},
            $urandom_range(0, 1), 5'($urandom_range(0, 9)), {$urandom, $urandom});
      address1 = 5'($urandom_range(0, 9));
      address2 = 5'($urandom_range(0, 9));
      step();
    end
    idle();
    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
